// File: rtl/video_timing_pkg.sv
// Shared PAL 625-line timing constants used by the sync generator and the active frame tracker.
package video_timing_pkg;

  localparam int unsigned CLK_DIV    = 6;
  localparam int unsigned H_TOTAL    = 864;
  localparam int unsigned LINES_ODD  = 313;
  localparam int unsigned LINES_EVEN = 312;

  localparam int unsigned ACTIVE_H_START     = 72;
  localparam int unsigned ACTIVE_V_START     = 23;
  localparam int unsigned ACTIVE_WIDTH       = 720;
  localparam int unsigned ACTIVE_FIELD_LINES = 288;

  localparam int unsigned DIV_W = 3;
  localparam int unsigned H_W   = 10;
  localparam int unsigned V_W   = 9;

  // Index of the last line of a field, sized to the line counter.
  function automatic logic [V_W-1:0] field_last_line(input logic odd,
                                                     input int unsigned lines_odd,
                                                     input int unsigned lines_even);
    field_last_line = odd ? V_W'(lines_odd - 1) : V_W'(lines_even - 1);
  endfunction

endpackage

// File: rtl/pal_sync_generator_if.sv
// Timing strobe bundle between the PAL sync generator and its consumers.
interface pal_sync_generator_if;
  import video_timing_pkg::*;

  logic           run;
  logic           dot_ce;
  logic           hsync;
  logic           vsync;
  logic           isFieldOdd;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;

  modport master (
    input  run,
    output dot_ce, hsync, vsync, isFieldOdd, h_count, v_count
  );

  modport slave (
    output run,
    input  dot_ce, hsync, vsync, isFieldOdd, h_count, v_count
  );
endinterface

// File: rtl/dot_clock_enable.sv
// Dot-clock divider: div_cnt counts 0..CLK_DIV-1 and a registered dot_ce marks div_cnt == 0.
module dot_clock_enable
  import video_timing_pkg::DIV_W;
#(
  parameter int unsigned CLK_DIV = video_timing_pkg::CLK_DIV
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             run,
  output logic [DIV_W-1:0] div_cnt_next,
  output logic             dot_step,
  output logic             dot_ce
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             run_q, run_d;
  logic             dot_ce_q, dot_ce_d;
  logic             step;

  // The first edge with run sampled high keeps the counter at origin so the
  // origin strobes are emitted on that edge; counting starts on the next one.
  always_comb begin
    div_cnt_d = '0;
    step      = 1'b0;
    run_d     = run;
    if (run && run_q) begin
      if (div_cnt_q >= DIV_LAST) begin
        div_cnt_d = '0;
        step      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
    dot_ce_d = run && (div_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      div_cnt_q <= '0;
      run_q     <= 1'b0;
      dot_ce_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      run_q     <= run_d;
      dot_ce_q  <= dot_ce_d;
    end
  end

  assign div_cnt_next = div_cnt_d;
  assign dot_step     = step;
  assign dot_ce       = dot_ce_q;

endmodule

// File: rtl/pal_sync_generator.sv
// PAL interlaced sync generator: dot/line/field counters with single-cycle hsync, vsync and dot_ce strobes.
module pal_sync_generator #(
  parameter int unsigned CLK_DIV    = video_timing_pkg::CLK_DIV,
  parameter int unsigned H_TOTAL    = video_timing_pkg::H_TOTAL,
  parameter int unsigned LINES_ODD  = video_timing_pkg::LINES_ODD,
  parameter int unsigned LINES_EVEN = video_timing_pkg::LINES_EVEN
) (
  input  logic                  clk,
  input  logic                  nReset,
  pal_sync_generator_if.master  sync
);
  import video_timing_pkg::*;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt_next;
  logic             dot_step;
  logic             dot_ce;

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic [V_W-1:0] v_last;
  logic           odd_q, odd_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;

  dot_clock_enable #(
    .CLK_DIV (CLK_DIV)
  ) u_dot_clock_enable (
    .clk          (clk),
    .nReset       (nReset),
    .run          (sync.run),
    .div_cnt_next (div_cnt_next),
    .dot_step     (dot_step),
    .dot_ce       (dot_ce)
  );

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    odd_d  = odd_q;
    v_last = field_last_line(odd_q, LINES_ODD, LINES_EVEN);
    if (!sync.run) begin
      h_d   = '0;
      v_d   = '0;
      odd_d = 1'b1;
    end else if (dot_step) begin
      if (h_q >= H_LAST) begin
        h_d = '0;
        if (v_q >= v_last) begin
          v_d   = '0;
          odd_d = ~odd_q;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Strobes decode the post-edge counter state so each register lines up
    // with the counter value it describes; vsync lands one dot-phase later.
    hsync_d = sync.run && (div_cnt_next == '0) && (h_d == '0);
    vsync_d = sync.run && (div_cnt_next == DIV_W'(1)) && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      h_q     <= '0;
      v_q     <= '0;
      odd_q   <= 1'b1;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      odd_q   <= odd_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign sync.dot_ce     = dot_ce;
  assign sync.hsync      = hsync_q;
  assign sync.vsync      = vsync_q;
  assign sync.isFieldOdd = odd_q;
  assign sync.h_count    = h_q;
  assign sync.v_count    = v_q;

endmodule

// File: tb/tb_pal_sync_generator.sv
// Scoreboard bench: full-size PAL instance plus a shrunk instance that reaches field and frame wraps quickly.
`timescale 1ns/1ps
module tb_pal_sync_generator;
  import video_timing_pkg::*;

  localparam int unsigned S_DIV = 6;
  localparam int unsigned S_HT  = 12;
  localparam int unsigned S_LO  = 5;
  localparam int unsigned S_LE  = 4;

  typedef struct packed {
    logic       dot_ce;
    logic       hsync;
    logic       vsync;
    logic       odd;
    logic [9:0] h;
    logic [8:0] v;
  } obs_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  pal_sync_generator_if big_if();
  pal_sync_generator_if small_if();
  assign big_if.run   = run;
  assign small_if.run = run;

  pal_sync_generator u_big (
    .clk    (clk),
    .nReset (nReset),
    .sync   (big_if.master)
  );

  pal_sync_generator #(
    .CLK_DIV    (S_DIV),
    .H_TOTAL    (S_HT),
    .LINES_ODD  (S_LO),
    .LINES_EVEN (S_LE)
  ) u_small (
    .clk    (clk),
    .nReset (nReset),
    .sync   (small_if.master)
  );

  obs_t big_o, small_o;
  assign big_o   = {big_if.dot_ce, big_if.hsync, big_if.vsync, big_if.isFieldOdd,
                    big_if.h_count, big_if.v_count};
  assign small_o = {small_if.dot_ce, small_if.hsync, small_if.vsync, small_if.isFieldOdd,
                    small_if.h_count, small_if.v_count};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  longint cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs after the n-th edge of continuous running (n = 0 is the first run edge).
  function automatic obs_t model(input bit active, input int unsigned n, input int unsigned cd,
                                 input int unsigned ht, input int unsigned lo, input int unsigned le);
    obs_t o;
    int unsigned div, dot, h, line, lf, v;
    bit odd;
    o = '0;
    o.odd = 1'b1;
    if (!active) return o;
    div  = n % cd;
    dot  = n / cd;
    h    = dot % ht;
    line = dot / ht;
    lf   = line % (lo + le);
    odd  = (lf < lo);
    v    = odd ? lf : lf - lo;
    o.dot_ce = (div == 0);
    o.hsync  = (div == 0) && (h == 0);
    o.vsync  = (div == 1) && (h == 0) && (v == 0);
    o.odd    = odd;
    o.h      = h[9:0];
    o.v      = v[8:0];
    return o;
  endfunction

  obs_t q_big[$];
  obs_t q_small[$];
  obs_t rst_exp;
  bit run_prev = 1'b0;
  int unsigned n_run = 0;

  longint big_last_h = -1, big_last_ce = -1, small_last_h = -1, small_last_v = -1;
  int unsigned small_fld = 0;

  initial rst_exp = model(1'b0, 0, 1, 1, 1, 1);

  task automatic invalidate_monitors();
    big_last_h   = -1;
    big_last_ce  = -1;
    small_last_h = -1;
    small_last_v = -1;
    small_fld    = 0;
  endtask

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      run_prev = 1'b0;
      n_run = 0;
      q_big.delete();
      q_small.delete();
      invalidate_monitors();
    end else begin
      cyc++;
      if (run) n_run = run_prev ? n_run + 1 : 0;
      else invalidate_monitors();
      q_big.push_back(model(run, n_run, CLK_DIV, H_TOTAL, LINES_ODD, LINES_EVEN));
      q_small.push_back(model(run, n_run, S_DIV, S_HT, S_LO, S_LE));
      run_prev = run;
    end
  end

  always @(negedge clk) begin
    if (!nReset) begin
      check_eq("rst_big", 32'(big_o), 32'(rst_exp));
      check_eq("rst_small", 32'(small_o), 32'(rst_exp));
    end else begin
      if (q_big.size() > 0) check_eq("big", 32'(big_o), 32'(q_big.pop_front()));
      if (q_small.size() > 0) check_eq("small", 32'(small_o), 32'(q_small.pop_front()));

      if (big_if.dot_ce) begin
        if (big_last_ce >= 0) check_eq("big_dot_period", 32'(cyc - big_last_ce), 32'(CLK_DIV));
        big_last_ce = cyc;
      end
      if (big_if.hsync) begin
        if (big_last_h >= 0) check_eq("big_line_period", 32'(cyc - big_last_h), 32'(H_TOTAL * CLK_DIV));
        big_last_h = cyc;
      end
      if (big_if.vsync) check_eq("big_vsync_after_hsync", 32'(cyc - big_last_h), 32'd1);

      if (small_if.hsync) small_last_h = cyc;
      if (small_if.vsync) begin
        check_eq("small_vsync_after_hsync", 32'(cyc - small_last_h), 32'd1);
        if (small_last_v >= 0)
          check_eq("small_field_period", 32'(cyc - small_last_v),
                   ((small_fld - 1) % 2 == 0) ? 32'(S_LO * S_HT * S_DIV) : 32'(S_LE * S_HT * S_DIV));
        small_fld++;
        small_last_v = cyc;
      end
    end
  end

  initial begin
    int unsigned i;
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (4) @(negedge clk);

    run = 1'b1;
    i = 0;
    while (i < 20000 && !(big_if.h_count == 10'd400 && big_if.v_count == 9'd1)) begin
      @(negedge clk);
      i++;
    end
    check_eq("reach_h400_v1", {13'd0, big_if.v_count, big_if.h_count}, {13'd0, 9'd1, 10'd400});

    run = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b1;
    repeat (3000) @(negedge clk);

    #2 nReset = 1'b0;
    #1;
    check_eq("async_rst_big", 32'(big_o), 32'(rst_exp));
    check_eq("async_rst_small", 32'(small_o), 32'(rst_exp));
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (6000) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pal_sync_generator.md
Name: pal_sync_generator

Overview:
- Generates PAL 625-line interlaced timing strobes (hsync, vsync, field parity) from the 81 MHz system clock.
- Uses a 13.5 MHz dot-clock enable (81 MHz / 6).
- Drives the overlay/video path and acts as the local timing source that the active frame tracker consumes.
- Every strobe is a single-clk-cycle pulse, so downstream line and dot counters advance exactly once per event.

Parameters:
- CLK_DIV, 6, clk cycles per dot (81 MHz / 13.5 MHz).
- H_TOTAL, 864, dots per line.
- LINES_ODD, 313, lines in the odd field.
- LINES_EVEN, 312, lines in the even field.

Ports:
- clk  input  1  81 MHz system clock.
- nReset  input  1  asynchronous active-low reset.
- run  input  1  1 = generate timing; 0 = hold counters at origin and suppress all strobes.
- dot_ce  output  1  one-clk pulse per dot; high when div_cnt == 0.
- hsync  output  1  one-clk pulse at the start of each line.
- vsync  output  1  one-clk pulse at the start of each field; occurs the cycle after that line's hsync.
- isFieldOdd  output  1  1 = odd field, 0 = even field.
- h_count  output  10  current dot, 0..H_TOTAL-1.
- v_count  output  9  current field line, 0..LINES_x-1.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on nReset.
- Reset values: div_cnt=0, h_count=0, v_count=0, hsync=0, vsync=0, dot_ce=0, isFieldOdd=1 (first field after reset is odd).
- All outputs are registered.
- Counters:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - h_count increments when div_cnt wraps, and wraps at H_TOTAL-1.
  - v_count increments on h_count wrap, and wraps at LINES_ODD-1 when isFieldOdd=1, or at LINES_EVEN-1 when isFieldOdd=0.
- Field toggle: isFieldOdd toggles in the same clk edge on which v_count wraps to 0.
- Strobes:
  - hsync=1 for exactly one clk when div_cnt==0 and h_count==0.
  - dot_ce=1 whenever div_cnt==0.
  - vsync=1 for exactly one clk, on the cycle immediately after the hsync of line 0 (div_cnt==1, h_count==0, v_count==0).
  - The hsync-then-vsync ordering is mandatory: the downstream tracker increments its line count on hsync and resets it on vsync, and a coincident pulse would be lost.
- Periods:
  - line = 5184 clks.
  - odd field = 313 × 5184 = 1,622,592 clks.
  - even field = 312 × 5184 = 1,617,408 clks.
  - frame = 3,240,000 clks.
- run=0:
  - Synchronously clears div_cnt, h_count and v_count; forces hsync, vsync and dot_ce to 0.
  - isFieldOdd is set to 1.
  - Takes effect on the next edge, including mid-line and mid-field.
- run rising:
  - Counters sit at origin, so the first hsync and dot_ce occur on the first clk edge where run=1 is sampled.
  - The first vsync follows one clk later.
- Reset mid-operation: asynchronous clear to the reset values; restart behaves as a run rising edge.
- Width rules:
  - Compare counters against the parameters minus 1 at full counter width.
  - No counter may exceed its terminal value; out-of-range states wrap to 0 on the next increment.
- Simultaneous events: at end of frame, the h_count wrap, v_count wrap and isFieldOdd toggle all happen on one edge. The next hsync is then line 0 of the new field.

Decomposition:
- Shared package (video_timing_pkg):
  - CLK_DIV, H_TOTAL, LINES_ODD, LINES_EVEN.
  - Active-window constants ACTIVE_H_START=72, ACTIVE_V_START=23, ACTIVE_WIDTH=720, ACTIVE_FIELD_LINES=288.
  - The tracker and this block share these constants.
- One natural sub-module: dot_clock_enable (div_cnt counter plus dot_ce, with synchronous clear from run). The H/V counter and strobe logic stay in the top module.

Test Plan:
- Reset, then run=1 at t0 -> hsync at t0, vsync at t0+1, next hsync at t0+5184; dot_ce every 6 clks.
- Free-run one frame -> 313 hsyncs with isFieldOdd=1, then 312 with isFieldOdd=0. vsync interval 1,622,592 clks followed by 1,617,408 clks. Exactly one vsync per field, never coincident with hsync.
- Drop run to 0 at h_count=400, v_count=150 -> next edge: all counters 0, no strobes while low, isFieldOdd=1. Raising run again -> hsync on the first sampled edge.
- Assert nReset low mid-line for 3 clks -> outputs are immediately at reset values (async). After release with run=1, timing restarts from line 0 of the odd field.
- Connect to active_frame_tracker for 2 fields -> display_enable high for 720 × 288 dots per field. active_frame_line covers even values 0..574 in the even field and odd values 1..575 in the odd field.
- Boundary check at the last line of the even field (v_count=311, h_count=863, div_cnt=5) -> the next edge gives v_count=0, isFieldOdd=1, hsync=1.
